// File: rtl/seg7_pkg.sv
// Shared 7-segment display definitions: blanking constants, scan phase
// type and the hex-to-segment decode (gfedcba, active-low).
package seg7_pkg;

    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam logic [7:0] ANODE_OFF  = 8'hFF;
    localparam int         NUM_DIGITS = 8;

    typedef enum logic {
        PH_BLANK,
        PH_DRIVE
    } phase_t;

    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        logic [6:0] s;
        unique case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Host-side bundle of the scan controller.
// master: drives en/value_in/load, receives Display/Seg/frame_tick.
interface seg7_scan_ctrl_if;

    logic        en;
    logic [31:0] value_in;
    logic        load;
    logic [6:0]  Display;
    logic [7:0]  Seg;
    logic        frame_tick;

    modport master (
        output en, value_in, load,
        input  Display, Seg, frame_tick
    );

    modport slave (
        input  en, value_in, load,
        output Display, Seg, frame_tick
    );

endinterface

// File: rtl/seg7_prescaler.sv
// Clock-enable prescaler that times one digit slot and tracks its phase.
// Ports: clk, reset (sync, high), en; slot_end (last cycle), phase.
module seg7_prescaler
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 64
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    output logic   slot_end,
    output phase_t phase
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    // Last blank count; unused when there is no blank interval.
    localparam logic [CW-1:0] LAST_BLANK =
        CW'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);

    localparam phase_t START_PH =
        (BLANK_CYC == 0) ? PH_DRIVE : PH_BLANK;

    localparam bit HAS_BLANK = (BLANK_CYC != 0);

    logic [CW-1:0] cnt_q;
    phase_t        state_q, state_d;

    assign slot_end = (cnt_q == LAST);
    assign phase    = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= slot_end ? '0 : cnt_q + 1'b1;
        end
    end

    // The phase always reflects the current count: BLANK <=> cnt < BLANK_CYC.
    always_comb begin
        state_d = state_q;
        if (en) begin
            unique case (state_q)
                PH_BLANK: if (cnt_q == LAST_BLANK) state_d = PH_DRIVE;
                PH_DRIVE: if (slot_end && HAS_BLANK) state_d = PH_BLANK;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= START_PH;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Scans a 32-bit word onto an 8-digit common-anode display, tear-free.
// Ports: clk, reset (sync, high), bus (en/value_in/load in; Display/Seg/frame_tick out).
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 64,
    parameter bit LZ_BLANK  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    seg7_scan_ctrl_if.slave   bus
);

    logic        slot_end;
    phase_t      phase;
    logic [2:0]  idx_q;
    logic [31:0] shadow_q;
    logic [31:0] displayed_q;
    logic        pending_q;
    logic        frame_end;
    logic [4:0]  shamt;
    logic [31:0] upper;
    logic [3:0]  nib;
    logic        lz_hit;
    logic [6:0]  disp_d;
    logic [7:0]  seg_d;

    seg7_prescaler #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_pre (
        .clk      (clk),
        .reset    (reset),
        .en       (bus.en),
        .slot_end (slot_end),
        .phase    (phase)
    );

    assign frame_end = bus.en && slot_end
                     && (idx_q == 3'(NUM_DIGITS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= '0;
        end else if (bus.en && slot_end) begin
            idx_q <= idx_q + 3'd1;
        end
    end

    // A load landing on the boundary bypasses the shadow wait.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q    <= '0;
            displayed_q <= '0;
            pending_q   <= 1'b0;
        end else if (frame_end) begin
            if (bus.load) begin
                shadow_q    <= bus.value_in;
                displayed_q <= bus.value_in;
            end else if (pending_q) begin
                displayed_q <= shadow_q;
            end
            pending_q <= 1'b0;
        end else if (bus.load) begin
            shadow_q  <= bus.value_in;
            pending_q <= 1'b1;
        end
    end

    assign shamt  = {idx_q, 2'b00};
    assign upper  = displayed_q >> shamt;
    assign nib    = displayed_q[shamt +: 4];
    assign lz_hit = LZ_BLANK && (idx_q != 3'd0) && (upper == 32'd0);

    always_comb begin
        seg_d  = ANODE_OFF;
        disp_d = SEG_OFF;
        if (bus.en && phase == PH_DRIVE) begin
            seg_d = ~(8'b1 << idx_q);
            if (!lz_hit) disp_d = hex2seg(nib);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.Display    <= SEG_OFF;
            bus.Seg        <= ANODE_OFF;
            bus.frame_tick <= 1'b0;
        end else begin
            bus.Display    <= disp_d;
            bus.Seg        <= seg_d;
            bus.frame_tick <= frame_end;
        end
    end

endmodule
